// File: rtl/imem_access_arbiter.sv
// imem_access_arbiter
//   Shares a single-port instruction memory between the core fetch path
//   (read-only) and the program loader / debug port (write-only).
//   After reset the core is held off (BOOT) until the loader pulses ld_done;
//   afterwards both requesters are arbitrated with loader priority, bounded
//   to MAX_LD_STREAK consecutive loader grants while a fetch is waiting.
//   Misaligned or out-of-range fetches return NOP_INSTR with fetch_err set,
//   misaligned or out-of-range writes are dropped and flagged on ld_err.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   fetch_req/addr           core fetch request (byte address)
//   fetch_gnt                fetch accepted this cycle (combinational)
//   fetch_rvalid/rdata/err   registered fetch response, one cycle after grant
//   ld_req/addr/wdata        loader write request (byte address)
//   ld_gnt                   write accepted this cycle (combinational)
//   ld_err                   registered pulse after a granted illegal write
//   ld_done                  one-cycle pulse ending BOOT
//   boot_busy                high while in BOOT
//   mem_addr/we/wdata/rdata  memory port (combinational read of mem_addr)

module imem_access_arbiter #(
    parameter int          MEM_SIZE      = 128,
    parameter int          MAX_LD_STREAK = 4,
    parameter logic [31:0] NOP_INSTR     = 32'h00000013,
    localparam int         ADDR_WIDTH    = $clog2(MEM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  fetch_req,
    input  logic [31:0]           fetch_addr,
    output logic                  fetch_gnt,
    output logic                  fetch_rvalid,
    output logic [31:0]           fetch_rdata,
    output logic                  fetch_err,

    input  logic                  ld_req,
    input  logic [31:0]           ld_addr,
    input  logic [31:0]           ld_wdata,
    output logic                  ld_gnt,
    output logic                  ld_err,
    input  logic                  ld_done,

    output logic                  boot_busy,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam int          SW        = $clog2(MAX_LD_STREAK + 1);
    localparam logic [29:0] MEM_WORDS = 30'(MEM_SIZE);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LD_STREAK);

    typedef enum logic {BOOT, RUN} state_t;

    state_t        state;
    logic [SW-1:0] ld_streak;
    logic          fetch_legal;
    logic          ld_legal;
    logic          streak_full;

    assign fetch_legal = (fetch_addr[1:0] == 2'b00) && (fetch_addr[31:2] < MEM_WORDS);
    assign ld_legal    = (ld_addr[1:0] == 2'b00) && (ld_addr[31:2] < MEM_WORDS);
    assign streak_full = (ld_streak == STREAK_MAX);
    assign boot_busy   = (state == BOOT);

    // Grant selection: at most one grant per cycle.
    always_comb begin
        fetch_gnt = 1'b0;
        ld_gnt    = 1'b0;
        if (state == BOOT) begin
            ld_gnt = ld_req;
        end else if (ld_req && fetch_req) begin
            // Loader keeps priority until it has starved the core for
            // MAX_LD_STREAK consecutive cycles.
            if (streak_full) fetch_gnt = 1'b1;
            else             ld_gnt    = 1'b1;
        end else begin
            ld_gnt    = ld_req;
            fetch_gnt = fetch_req;
        end
    end

    // Memory port steering.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (ld_gnt) begin
            mem_addr  = ld_addr[ADDR_WIDTH+1:2];
            mem_we    = ld_legal;
            mem_wdata = ld_wdata;
        end else if (fetch_gnt) begin
            mem_addr  = fetch_addr[ADDR_WIDTH+1:2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BOOT;
            ld_streak    <= '0;
            fetch_rvalid <= 1'b0;
            fetch_err    <= 1'b0;
            fetch_rdata  <= NOP_INSTR;
            ld_err       <= 1'b0;
        end else begin
            if (state == BOOT && ld_done) state <= RUN;

            // Streak only counts loader wins against a waiting fetch; fetch
            // is not arbitrated in BOOT so the counter is idle there.
            if (state == BOOT || fetch_gnt || !fetch_req)
                ld_streak <= '0;
            else if (ld_gnt && !streak_full)
                ld_streak <= ld_streak + 1'b1;

            fetch_rvalid <= fetch_gnt;
            fetch_err    <= fetch_gnt && !fetch_legal;
            if (fetch_gnt)
                fetch_rdata <= fetch_legal ? mem_rdata : NOP_INSTR;

            ld_err <= ld_gnt && !ld_legal;
        end
    end

endmodule

// File: tb/tb_imem_access_arbiter.sv
module tb_imem_access_arbiter;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_rvalid;
    logic [31:0] fetch_rdata;
    logic        fetch_err;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_gnt;
    logic        ld_err;
    logic        ld_done;
    logic        boot_busy;
    logic [6:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem_model [0:127];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imem_access_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_gnt    (fetch_gnt),
        .fetch_rvalid (fetch_rvalid),
        .fetch_rdata  (fetch_rdata),
        .fetch_err    (fetch_err),
        .ld_req       (ld_req),
        .ld_addr      (ld_addr),
        .ld_wdata     (ld_wdata),
        .ld_gnt       (ld_gnt),
        .ld_err       (ld_err),
        .ld_done      (ld_done),
        .boot_busy    (boot_busy),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Single-port memory: combinational read, write on the clock edge.
    assign mem_rdata = mem_model[mem_addr];
    always @(posedge clk) if (mem_we) mem_model[mem_addr] <= mem_wdata;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total++; if (boot_busy !== 1'b1) begin bad++; $display("FAIL reset_boot_busy got=%b exp=1", boot_busy); end
        total++; if (fetch_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0", fetch_rvalid); end
        total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", fetch_err); end
        total++; if (fetch_rdata !== NOP) begin bad++; $display("FAIL reset_rdata got=%h exp=%h", fetch_rdata, NOP); end
        total++; if (ld_err !== 1'b0) begin bad++; $display("FAIL reset_ld_err got=%b exp=0", ld_err); end
        // Fetch is held off in BOOT.
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (fetch_gnt !== 1'b0) begin bad++; $display("FAIL boot_fetch_gnt cyc=%0d got=%b exp=0", i, fetch_gnt); end
            step();
            total++; if (fetch_rvalid !== 1'b0) begin bad++; $display("FAIL boot_rvalid cyc=%0d got=%b exp=0", i, fetch_rvalid); end
            total++; if (boot_busy !== 1'b1) begin bad++; $display("FAIL boot_busy cyc=%0d got=%b exp=1", i, boot_busy); end
        end
        fetch_req = 1'b0;
        #1;
        total++; if (mem_addr !== 7'd0) begin bad++; $display("FAIL idle_mem_addr got=%0d exp=0", mem_addr); end
    endtask

    task automatic test_boot_load();
        ld_req   = 1'b1;
        ld_addr  = 32'h0;
        ld_wdata = 32'h00500093;
        #1;
        total++; if (ld_gnt !== 1'b1) begin bad++; $display("FAIL boot_ld_gnt got=%b exp=1", ld_gnt); end
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL boot_mem_we got=%b exp=1", mem_we); end
        step();
        ld_addr  = 32'h4;
        ld_wdata = 32'h00108113;
        ld_done  = 1'b1;
        #1;
        total++; if (mem_addr !== 7'd1) begin bad++; $display("FAIL boot_mem_addr got=%0d exp=1", mem_addr); end
        step();
        ld_req  = 1'b0;
        ld_done = 1'b0;
        total++; if (boot_busy !== 1'b0) begin bad++; $display("FAIL run_boot_busy got=%b exp=0", boot_busy); end
        total++; if (mem_model[1] !== 32'h00108113) begin bad++; $display("FAIL done_cycle_write got=%h exp=00108113", mem_model[1]); end

        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        #1;
        total++; if (fetch_gnt !== 1'b1) begin bad++; $display("FAIL run_fetch_gnt got=%b exp=1", fetch_gnt); end
        step();
        fetch_addr = 32'h4;
        total++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'h00500093 || fetch_err !== 1'b0)
            begin bad++; $display("FAIL fetch0 got=%b/%h/%b exp=1/00500093/0", fetch_rvalid, fetch_rdata, fetch_err); end
        step();
        fetch_req = 1'b0;
        total++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'h00108113 || fetch_err !== 1'b0)
            begin bad++; $display("FAIL fetch4 got=%b/%h/%b exp=1/00108113/0", fetch_rvalid, fetch_rdata, fetch_err); end
        step();
        total++; if (fetch_rvalid !== 1'b0 || fetch_rdata !== 32'h00108113)
            begin bad++; $display("FAIL rdata_hold got=%b/%h exp=0/00108113", fetch_rvalid, fetch_rdata); end
    endtask

    task automatic test_illegal_fetch();
        logic [31:0] addrs [2];
        addrs[0] = 32'h200;
        addrs[1] = 32'h2;
        for (int i = 0; i < 2; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = addrs[i];
            #1;
            total++; if (fetch_gnt !== 1'b1 || mem_we !== 1'b0)
                begin bad++; $display("FAIL ill_fetch_gnt addr=%h got=%b/%b exp=1/0", addrs[i], fetch_gnt, mem_we); end
            step();
            fetch_req = 1'b0;
            total++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== NOP || fetch_err !== 1'b1)
                begin bad++; $display("FAIL ill_fetch addr=%h got=%b/%h/%b exp=1/%h/1", addrs[i], fetch_rvalid, fetch_rdata, fetch_err, NOP); end
            step();
            total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL ill_err_clear addr=%h got=%b exp=0", addrs[i], fetch_err); end
        end
        total++; if (mem_model[0] !== 32'h00500093 || mem_model[1] !== 32'h00108113)
            begin bad++; $display("FAIL ill_mem_unchanged got=%h/%h", mem_model[0], mem_model[1]); end
    endtask

    task automatic test_write_then_fetch();
        ld_req   = 1'b1;
        ld_addr  = 32'h1FC;
        ld_wdata = 32'hDEADBEEF;
        #1;
        total++; if (mem_we !== 1'b1 || mem_addr !== 7'd127 || mem_wdata !== 32'hDEADBEEF)
            begin bad++; $display("FAIL wr127 got=%b/%0d/%h exp=1/127/deadbeef", mem_we, mem_addr, mem_wdata); end
        step();
        ld_req     = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 32'h1FC;
        total++; if (ld_err !== 1'b0) begin bad++; $display("FAIL wr127_ld_err got=%b exp=0", ld_err); end
        step();
        fetch_req = 1'b0;
        total++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'hDEADBEEF || fetch_err !== 1'b0)
            begin bad++; $display("FAIL raw_fetch got=%b/%h/%b exp=1/deadbeef/0", fetch_rvalid, fetch_rdata, fetch_err); end

        ld_req   = 1'b1;
        ld_addr  = 32'h200;
        ld_wdata = 32'h12345678;
        #1;
        total++; if (ld_gnt !== 1'b1 || mem_we !== 1'b0)
            begin bad++; $display("FAIL wr_oor got gnt=%b we=%b exp=1/0", ld_gnt, mem_we); end
        step();
        ld_req = 1'b0;
        total++; if (ld_err !== 1'b1) begin bad++; $display("FAIL ld_err_pulse got=%b exp=1", ld_err); end
        step();
        total++; if (ld_err !== 1'b0) begin bad++; $display("FAIL ld_err_clear got=%b exp=0", ld_err); end
        total++; if (mem_model[0] !== 32'h00500093) begin bad++; $display("FAIL oor_alias got=%h exp=00500093", mem_model[0]); end
    endtask

    task automatic test_contention();
        ld_req     = 1'b1;
        ld_addr    = 32'h10;
        ld_wdata   = 32'hA5A5A5A5;
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        for (int i = 0; i < 12; i++) begin
            logic exp_f;
            exp_f = ((i % 5) == 4);
            #1;
            total++; if (fetch_gnt !== exp_f || ld_gnt !== !exp_f)
                begin bad++; $display("FAIL contention cyc=%0d got f=%b l=%b exp f=%b l=%b", i, fetch_gnt, ld_gnt, exp_f, !exp_f); end
            step();
        end
        ld_req    = 1'b0;
        fetch_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        // Reset on the cycle a fetch is granted: its response must vanish.
        fetch_req  = 1'b1;
        fetch_addr = 32'h4;
        ld_req     = 1'b1;
        ld_addr    = 32'h20;
        ld_wdata   = 32'h11111111;
        step(); // loader granted, streak 1
        rst = 1'b1;
        ld_req = 1'b0;  // fetch alone -> granted in the reset cycle
        step();
        rst = 1'b0;
        total++; if (fetch_rvalid !== 1'b0 || boot_busy !== 1'b1 || fetch_rdata !== NOP)
            begin bad++; $display("FAIL rst_mid got=%b/%b/%h exp=0/1/%h", fetch_rvalid, boot_busy, fetch_rdata, NOP); end
        #1;
        total++; if (fetch_gnt !== 1'b0) begin bad++; $display("FAIL rst_boot_gnt got=%b exp=0", fetch_gnt); end
        fetch_req = 1'b0;
        ld_done   = 1'b1;
        step();
        ld_done = 1'b0;

        // Build up a streak of 3, reset, and expect the full 4-grant budget.
        ld_req    = 1'b1;
        fetch_req = 1'b1;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst     = 1'b0;
        ld_done = 1'b1;
        step();
        ld_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            logic exp_f;
            exp_f = (i == 4);
            #1;
            total++; if (fetch_gnt !== exp_f || ld_gnt !== !exp_f)
                begin bad++; $display("FAIL rst_streak cyc=%0d got f=%b l=%b exp f=%b", i, fetch_gnt, ld_gnt, exp_f); end
            step();
        end
        ld_req    = 1'b0;
        fetch_req = 1'b0;
        step();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem_model[i] = 32'h0;
        rst        = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = 32'h0;
        ld_req     = 1'b0;
        ld_addr    = 32'h0;
        ld_wdata   = 32'h0;
        ld_done    = 1'b0;
        test_reset();
        test_boot_load();
        test_illegal_fetch();
        test_write_then_fetch();
        test_contention();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_access_arbiter.md
Name: imem_access_arbiter

Overview:
- Sequences and shares the single-port instruction memory between two requesters: the core fetch path (read-only) and the program loader/debug port (write-only).
- After reset it holds the core in a BOOT phase until the loader signals completion, then arbitrates both requesters with bounded loader priority.
- Performs word alignment and range checks. Illegal fetches return a NOP (addi x0,x0,0 = 0x00000013) without accessing memory.

Parameters:
- MEM_SIZE, 128, memory depth in 32-bit words.
- ADDR_WIDTH, $clog2(MEM_SIZE), word-index width driven to memory (localparam, not overridable).
- MAX_LD_STREAK, 4, maximum consecutive loader grants while a fetch is pending; must be ≥1.
- NOP_INSTR, 32'h00000013, instruction returned on illegal fetch and after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- fetch_req  input  1  core requests an instruction read this cycle.
- fetch_addr  input  32  byte address of the fetch.
- fetch_gnt  output  1  fetch accepted this cycle (combinational).
- fetch_rvalid  output  1  registered response valid, one cycle after fetch_gnt.
- fetch_rdata  output  32  returned instruction.
- fetch_err  output  1  qualifies fetch_rvalid: misaligned or out-of-range address.
- ld_req  input  1  loader requests a word write.
- ld_addr  input  32  byte address of the write.
- ld_wdata  input  32  write data.
- ld_gnt  output  1  write accepted this cycle (combinational).
- ld_err  output  1  registered pulse, one cycle after a granted out-of-range or misaligned write.
- ld_done  input  1  one-cycle pulse: boot load complete.
- boot_busy  output  1  high while in BOOT.
- mem_addr  output  ADDR_WIDTH  word index to memory.
- mem_we  output  1  memory write enable.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory read data (combinational read of mem_addr).

Behaviour:
- Reset values:
  - state = BOOT, boot_busy = 1.
  - fetch_rvalid = 0, fetch_err = 0, fetch_rdata = NOP_INSTR.
  - ld_err = 0, ld_streak = 0.
  - Reset mid-transaction discards any pending response; fetch_rvalid is 0 on the cycle after rst.
- Address decode, per requester:
  - word index = addr[31:2].
  - legal iff addr[1:0] == 0 and addr[31:2] < MEM_SIZE.
  - mem_addr = addr[ADDR_WIDTH+1:2] of the granted requester; 0 when idle.
- FSM:
  - BOOT:
    - fetch_gnt = 0 and fetch_req is ignored.
    - ld_req is granted every cycle.
    - ld_done = 1 → RUN next cycle. A write granted in the same cycle as ld_done still completes.
  - RUN:
    - Both requesters are arbitrated. ld_done is ignored.
    - RUN → BOOT only via rst.
- Arbitration in RUN, at most one grant per cycle:
  - Only one requester → grant it.
  - Both requesting → loader wins, unless ld_streak == MAX_LD_STREAK, in which case fetch wins.
  - ld_streak increments when the loader is granted while fetch_req = 1.
  - ld_streak clears when fetch is granted, or when fetch_req = 0. It saturates at MAX_LD_STREAK.
- Loader write:
  - On ld_gnt: mem_wdata = ld_wdata, and mem_we = 1 only if the address is legal.
  - Illegal address → no write; ld_err = 1 on the next cycle.
  - Granted writes take effect on the same clock edge.
- Fetch read:
  - On fetch_gnt with a legal address: mem_we = 0, and mem_rdata is captured into fetch_rdata at the edge.
  - Next cycle: fetch_rvalid = 1, fetch_err = 0.
  - Illegal address: memory is not accessed. Next cycle: fetch_rvalid = 1, fetch_rdata = NOP_INSTR, fetch_err = 1.
  - fetch_rdata holds its last value when fetch_rvalid = 0.
- Throughput and hazards:
  - One fetch per cycle when uncontended; back-to-back responses are allowed.
  - A fetch granted the cycle after a write to the same word returns the new data.
  - Requesters hold req/addr/data stable until granted.

Test Plan:
- Reset, then fetch_req = 1 at 0x0 with no ld_done → fetch_gnt stays 0, boot_busy = 1, fetch_rvalid = 0.
- BOOT: write 0x00500093 to 0x0 and 0x00108113 to 0x4, pulse ld_done → boot_busy = 0 next cycle. Fetch 0x0 then 0x4 → rvalid on consecutive cycles with those words, err = 0.
- RUN: fetch 0x200 (word 128) and fetch 0x2 → each returns rdata = 0x00000013, fetch_err = 1, memory unchanged.
- RUN: loader write to 0x1FC (word 127) with 0xDEADBEEF, then fetch 0x1FC → 0xDEADBEEF. Loader write to 0x200 → mem_we = 0, ld_err pulse.
- Contention: ld_req and fetch_req both held high for 12 cycles → grant pattern L,L,L,L,F repeating (MAX_LD_STREAK = 4). Never two grants in one cycle.
- Assert rst while a fetch response is pending and the loader is mid-stream → next cycle fetch_rvalid = 0, state = BOOT, ld_streak = 0.
